// File: rtl/sm_addsub_norm.sv
// sm_addsub_norm
//   Multi-cycle sign-magnitude adder/subtractor with optional left
//   normalisation. Forms the mantissa datapath of the FP calculator.
//
//   Flow: IDLE/DONE --start--> COMPUTE --> (NORM)* --> DONE
//     COMPUTE : forms the signed result of the latched operands in one cycle.
//     NORM    : shifts the magnitude left one bit per cycle until the MSB is set,
//               counting the shifts in lz_count for exponent adjustment.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   en              : clock enable; low freezes everything and ignores start
//   start           : request, accepted when ready=1 and en=1
//   plus_or_minus   : 0 = A+B, 1 = A-B
//   a, b            : operand magnitudes (WIDTH bits)
//   sign_a, sign_b  : operand signs (1 = negative)
//   ready           : can accept start (IDLE or DONE)
//   busy            : COMPUTE or NORM
//   done            : one-cycle pulse, result valid
//   sum             : result magnitude (normalised when NORM_EN)
//   sign_s          : result sign
//   c_out           : magnitude overflow of an effective add
//   zero            : result magnitude is zero
//   lz_count        : number of left shifts applied (WIDTH for a zero result)

module sm_addsub_norm #(
    parameter int WIDTH   = 24,
    parameter bit NORM_EN = 1'b1,
    parameter int LZW     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             plus_or_minus,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sign_a,
    input  logic             sign_b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             sign_s,
    output logic             c_out,
    output logic             zero,
    output logic [LZW-1:0]   lz_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_NORM    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Latched operands
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic             pm_q, pm_d;

    // Result registers
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             sign_q, sign_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic [LZW-1:0]   lz_q, lz_d;
    logic             done_q, done_d;

    // ------------------------------------------------------------------
    // Arithmetic on the latched operands (only consumed in COMPUTE)
    // ------------------------------------------------------------------
    logic             eff_sub;
    logic [WIDTH:0]   add_full;
    logic             a_ge_b;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] res_mag;
    logic             res_cout;
    logic             res_sign;
    logic             res_zero;
    logic             need_norm;

    assign eff_sub  = pm_q ^ sa_q ^ sb_q;
    assign add_full = {1'b0, a_q} + {1'b0, b_q};
    assign a_ge_b   = (a_q >= b_q);
    assign diff     = a_ge_b ? (a_q - b_q) : (b_q - a_q);

    always_comb begin
        res_mag  = '0;
        res_cout = 1'b0;
        res_sign = 1'b0;
        if (!eff_sub) begin
            res_mag  = add_full[WIDTH-1:0];
            res_cout = add_full[WIDTH];
            res_sign = sa_q;
        end else begin
            res_mag  = diff;
            res_cout = 1'b0;
            res_sign = a_ge_b ? sa_q : ~sa_q;
        end
    end

    // A carry-out means the true magnitude is 2^WIDTH + sum, never zero.
    assign res_zero  = ~res_cout & ~(|res_mag);
    assign need_norm = NORM_EN & ~res_cout & ~res_zero & ~res_mag[WIDTH-1];

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        pm_d    = pm_q;
        sum_d   = sum_q;
        sign_d  = sign_q;
        cout_d  = cout_q;
        zero_d  = zero_q;
        lz_d    = lz_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sa_d    = sign_a;
                    sb_d    = sign_b;
                    pm_d    = plus_or_minus;
                    state_d = S_COMPUTE;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end

            S_COMPUTE: begin
                sum_d  = res_mag;
                cout_d = res_cout;
                zero_d = res_zero;
                // Zero is reported as positive zero, fully "shifted out".
                sign_d = res_zero ? 1'b0 : res_sign;
                lz_d   = res_zero ? LZW'(WIDTH) : '0;
                if (need_norm) begin
                    state_d = S_NORM;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end

            S_NORM: begin
                sum_d = sum_q << 1;
                lz_d  = lz_q + LZW'(1);
                // The bit moving into the MSB on this edge ends normalisation.
                if (sum_q[WIDTH-2]) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers; en=0 freezes everything including a pending done
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            pm_q    <= 1'b0;
            sum_q   <= '0;
            sign_q  <= 1'b0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            lz_q    <= '0;
            done_q  <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            pm_q    <= pm_d;
            sum_q   <= sum_d;
            sign_q  <= sign_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
            lz_q    <= lz_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all registered or decoded from registered state
    // ------------------------------------------------------------------
    assign ready    = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy     = (state_q == S_COMPUTE) || (state_q == S_NORM);
    assign done     = done_q;
    assign sum      = sum_q;
    assign sign_s   = sign_q;
    assign c_out    = cout_q;
    assign zero     = zero_q;
    assign lz_count = lz_q;

endmodule

// File: tb/tb_sm_addsub_norm.sv
module tb_sm_addsub_norm;

    localparam int W   = 24;
    localparam int LZW = $clog2(W + 1);

    logic clk, rst, en;
    logic start0, start1;
    logic pm, sa, sb;
    logic [W-1:0] ta, tb;

    logic         rdy0, bsy0, dn0, ss0, co0, z0;
    logic [W-1:0] s0;
    logic [LZW-1:0] lz0;
    logic         rdy1, bsy1, dn1, ss1, co1, z1;
    logic [W-1:0] s1;
    logic [LZW-1:0] lz1;

    sm_addsub_norm #(.WIDTH(W), .NORM_EN(1'b1)) u_norm (
        .clk(clk), .rst(rst), .en(en), .start(start0), .plus_or_minus(pm),
        .a(ta), .b(tb), .sign_a(sa), .sign_b(sb),
        .ready(rdy0), .busy(bsy0), .done(dn0), .sum(s0), .sign_s(ss0),
        .c_out(co0), .zero(z0), .lz_count(lz0)
    );

    sm_addsub_norm #(.WIDTH(W), .NORM_EN(1'b0)) u_raw (
        .clk(clk), .rst(rst), .en(en), .start(start1), .plus_or_minus(pm),
        .a(ta), .b(tb), .sign_a(sa), .sign_b(sb),
        .ready(rdy1), .busy(bsy1), .done(dn1), .sum(s1), .sign_s(ss1),
        .c_out(co1), .zero(z1), .lz_count(lz1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs of the instance under test
    bit cur;
    logic o_rdy, o_bsy, o_dn, o_ss, o_co, o_z;
    logic [W-1:0] o_s;
    logic [LZW-1:0] o_lz;
    always_comb begin
        o_rdy = cur ? rdy1 : rdy0;
        o_bsy = cur ? bsy1 : bsy0;
        o_dn  = cur ? dn1  : dn0;
        o_ss  = cur ? ss1  : ss0;
        o_co  = cur ? co1  : co0;
        o_z   = cur ? z1   : z0;
        o_s   = cur ? s1   : s0;
        o_lz  = cur ? lz1  : lz0;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: signed-magnitude arithmetic with plain integers, then
    // doubling until the top bit is reached.
    function automatic void model(input logic [W-1:0] ia, ib, input logic isa, isb, ipm,
                                  input bit norm, output logic [W-1:0] es,
                                  output logic ess, eco, ez, output int elz);
        longint ua = longint'(ia);
        longint ub = longint'(ib);
        longint full = longint'(1) << W;
        longint m;
        logic sg;
        logic co;
        if ((ipm ^ isa ^ isb) == 1'b0) begin
            m  = ua + ub;
            sg = isa;
            co = (m >= full);
            if (co) m = m - full;
        end else begin
            co = 1'b0;
            if (ua >= ub) begin m = ua - ub; sg = isa;  end
            else          begin m = ub - ua; sg = ~isa; end
        end
        elz = 0;
        ez  = 1'b0;
        if (!co && m == 0) begin
            ez = 1'b1; sg = 1'b0; elz = W;
        end else if (norm && !co) begin
            while (m < (full / 2)) begin m = m * 2; elz++; end
        end
        es  = W'(m);
        ess = sg;
        eco = co;
    endfunction

    // Called at a negedge; pulses start across exactly one rising edge (T0).
    task automatic launch(input bit sel, input logic [W-1:0] ia, ib,
                          input logic isa, isb, ipm);
        cur = sel;
        ta = ia; tb = ib; sa = isa; sb = isb; pm = ipm;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Counts edges from T0 (inclusive) until done is seen. Optionally drops
    // en for 3 cycles or re-pulses start with junk operands at a given count.
    task automatic wait_done(input string tag, input int gap_at, input int junk_at,
                             output int lat, output int bcyc);
        bit seen = 0;
        lat  = 1;
        bcyc = 0;
        for (int i = 0; i < 100; i++) begin
            if (o_bsy) bcyc++;
            if (o_dn) begin seen = 1; break; end
            if (lat == gap_at) begin
                en = 1'b0;
                repeat (3) @(negedge clk);
                en = 1'b1;
                lat += 3;
            end
            if (lat == junk_at) begin
                ta = 24'h000001; tb = 24'h000001; pm = 1'b0;
                start0 = 1'b1;
            end
            @(negedge clk);
            lat++;
            start0 = 1'b0;
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'(1));
        if (seen) chk({tag, "_ready_at_done"}, 64'(o_rdy), 64'(1));
    endtask

    task automatic run_op(input string tag, input bit sel, input logic [W-1:0] ia, ib,
                          input logic isa, isb, ipm, input int gap_at, input int junk_at,
                          output int bcyc);
        logic [W-1:0] es;
        logic ess, eco, ez;
        int elz, lat, exp_lat;
        model(ia, ib, isa, isb, ipm, !sel, es, ess, eco, ez, elz);
        exp_lat = (ez ? 2 : 2 + elz) + ((gap_at > 0) ? 3 : 0);
        launch(sel, ia, ib, isa, isb, ipm);
        wait_done(tag, gap_at, junk_at, lat, bcyc);
        chk({tag, "_sum"},  64'(o_s),  64'(es));
        chk({tag, "_sign"}, 64'(o_ss), 64'(ess));
        chk({tag, "_cout"}, 64'(o_co), 64'(eco));
        chk({tag, "_zero"}, 64'(o_z),  64'(ez));
        chk({tag, "_lz"},   64'(o_lz), 64'(elz));
        chk({tag, "_lat"},  64'(lat),  64'(exp_lat));
    endtask

    initial begin
        int bc, dn_cnt;
        logic [W-1:0] ra, rb;
        rst = 1'b1; en = 1'b1; start0 = 1'b0; start1 = 1'b0;
        ta = '0; tb = '0; sa = 1'b0; sb = 1'b0; pm = 1'b0; cur = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state for both instances
        for (int s = 0; s < 2; s++) begin
            cur = bit'(s);
            #1;
            chk("rst_ready", 64'(o_rdy), 64'(1));
            chk("rst_busy",  64'(o_bsy), 64'(0));
            chk("rst_done",  64'(o_dn),  64'(0));
            chk("rst_sum",   64'(o_s),   64'(0));
            chk("rst_lz",    64'(o_lz),  64'(0));
            chk("rst_flags", 64'({o_ss, o_co, o_z}), 64'(0));
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op("carry",  0, 24'h800000, 24'h800000, 0, 0, 0, 0, 0, bc);
        run_op("long",   0, 24'h800000, 24'h7FFFFF, 0, 0, 1, 0, 0, bc);
        chk("long_busy_cycles", 64'(bc), 64'(24));
        run_op("negres", 0, 24'h400000, 24'hC00000, 0, 0, 1, 0, 0, bc);
        run_op("zero",   0, 24'h123456, 24'h123456, 1, 0, 0, 0, 0, bc);
        run_op("junk",   0, 24'h800000, 24'h7FFFFF, 0, 0, 1, 0, 6, bc);
        run_op("engap",  0, 24'h800000, 24'h7FFFFF, 0, 0, 1, 7, 0, bc);

        // Reset during NORM
        launch(0, 24'h800000, 24'h7FFFFF, 0, 0, 1);
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", 64'(o_bsy), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ready", 64'(o_rdy), 64'(1));
        chk("mid_rst_busy",  64'(o_bsy), 64'(0));
        chk("mid_rst_done",  64'(o_dn),  64'(0));
        chk("mid_rst_sum",   64'(o_s),   64'(0));
        chk("mid_rst_lz",    64'(o_lz),  64'(0));
        chk("mid_rst_flags", 64'({o_ss, o_co, o_z}), 64'(0));
        dn_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (o_dn) dn_cnt++;
        end
        chk("mid_rst_no_done", 64'(dn_cnt), 64'(0));

        // No-normalise instance, then back-to-back start in the done cycle
        run_op("raw",  1, 24'h000010, 24'h000001, 0, 0, 0, 0, 0, bc);
        run_op("raw2", 1, 24'h000020, 24'h000003, 0, 1, 1, 0, 0, bc);

        // Randomised, issued back-to-back on both instances
        for (int i = 0; i < 300; i++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0: rb = W'($urandom);
                1: rb = ra ^ (W'($urandom) >> $urandom_range(0, W - 1));
                2: rb = ra;
                default: begin
                    ra = ra >> $urandom_range(0, W - 1);
                    rb = W'($urandom) >> $urandom_range(0, W - 1);
                end
            endcase
            run_op("rnd", bit'(i % 3 == 0), ra, rb, 1'($urandom), 1'($urandom),
                   1'($urandom), 0, 0, bc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
